button_debounce: RTL
====================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter TICK_DIV, default 250000, sample-tick period in clocks (2.5 ms at 100 MHz); legal 2..2^20.
REQ-002 SHALL have parameter STABLE_SAMPLES, default 4, consecutive equal samples needed to accept a level change; legal 2..15.
REQ-003 SHALL have port clock  input  1  sole clock; all flops rise-edge on it.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn  input  1  raw pushbutton; asynchronous and bouncy.
REQ-006 SHALL have port level  output  1  debounced button state.
REQ-007 SHALL have port press_pulse  output  1  one-clock strobe on accepted press.
REQ-008 SHALL have port release_pulse  output  1  one-clock strobe on accepted release.
REQ-009 SHALL have port toggle  output  1  run/stop latch, flips on each accepted press; drives the display scanner's start input.

Function
REQ-010 SHALL pass btn through a two-flop synchronizer (btn_s); no other logic SHALL read btn.
REQ-011 SHALL run a free-running tick counter 0..TICK_DIV-1, asserting tick for one clock when count = TICK_DIV-1, then wrapping to 0.
REQ-012 SHALL sample btn_s only in tick cycles; non-tick cycles SHALL NOT change the FSM or the sample counter.
REQ-013 SHALL implement FSM states IDLE, PRESS_CHK, PRESSED, REL_CHK, with a 4-bit sample counter cnt.
REQ-014 IDLE: tick & btn_s=1 -> PRESS_CHK, cnt=1; otherwise stay.
REQ-015 PRESS_CHK: tick & btn_s=1 -> cnt+1; when cnt+1 = STABLE_SAMPLES -> PRESSED, cnt=0; tick & btn_s=0 -> IDLE, cnt=0.
REQ-016 PRESSED: tick & btn_s=0 -> REL_CHK, cnt=1; otherwise stay.
REQ-017 REL_CHK: tick & btn_s=0 -> cnt+1; when cnt+1 = STABLE_SAMPLES -> IDLE, cnt=0; tick & btn_s=1 -> PRESSED, cnt=0.
REQ-018 level SHALL be registered: 1 in PRESSED and REL_CHK, 0 in IDLE and PRESS_CHK.
REQ-019 press_pulse SHALL be high for exactly the one clock after the PRESS_CHK->PRESSED transition; release_pulse likewise after REL_CHK->IDLE.
REQ-020 press_pulse and release_pulse SHALL never be high in the same cycle, and at most one of each SHALL occur per tick.
REQ-021 toggle SHALL invert in the same cycle press_pulse is high and hold otherwise.
REQ-022 Worst-case accept latency from a stable btn edge to the level change SHALL be at most 2 + STABLE_SAMPLES*TICK_DIV + 1 clocks.
REQ-023 A bounce shorter than STABLE_SAMPLES consecutive samples SHALL produce no level change and no pulse.
REQ-024 The tick counter width SHALL be ceil(log2(TICK_DIV)); cnt SHALL never exceed STABLE_SAMPLES.

Reset
REQ-025 While reset_n=0: FSM=IDLE; cnt, tick counter and synchronizer flops=0; level, press_pulse, release_pulse and toggle=0.
REQ-026 Reset asserted mid-operation (any state) SHALL take effect immediately, without waiting for a clock edge.
REQ-027 After reset_n deasserts, the first tick SHALL occur TICK_DIV clocks later; a button held through reset SHALL be accepted as a fresh press.

Configuration
REQ-028 Macro DEBOUNCE_TOGGLE_EN defined: toggle SHALL behave per REQ-021.
REQ-029 DEBOUNCE_TOGGLE_EN undefined: no toggle flop SHALL be built and toggle SHALL be driven constant 0; all other behaviour is unchanged.

Verification (TICK_DIV=4, STABLE_SAMPLES=3, DEBOUNCE_TOGGLE_EN defined unless stated)
REQ-030 Clean press: btn 0->1, held 40 clocks -> exactly one press_pulse within 15 clocks; level=1 from then on; toggle 0->1.
REQ-031 Bouncy press: btn alternates every 3 clocks for 24 clocks, then held 1 -> exactly one press_pulse, issued after the hold; no release_pulse.
REQ-032 Glitch: btn high for 6 clocks, then 0 -> no pulse; level stays 0; FSM returns to IDLE.
REQ-033 Two full press/release cycles -> press_pulse x2, release_pulse x2; toggle goes 0->1->0.
REQ-034 Reset mid PRESS_CHK: reset_n low for 3 clocks -> all outputs 0 immediately; btn still held -> one new press_pulse within 15 clocks of release.
REQ-035 DEBOUNCE_TOGGLE_EN undefined: rerun REQ-033 -> pulse counts identical; toggle stays 0 throughout.

Source files
------------

// File: rtl/button_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : button_debounce                                               |
// | Purpose  : Debounces a raw mechanical pushbutton. The button is          |
// |            synchronised, then sampled once per slow tick. A level change |
// |            is accepted only after STABLE_SAMPLES equal samples in a row.  |
// |            Produces the debounced level, one-clock press/release strobes |
// |            and an optional run/stop toggle latch.                        |
// | Params   : TICK_DIV       - sample-tick period in clocks (2..2^20)       |
// |            STABLE_SAMPLES - equal samples needed to accept (2..15)       |
// | Ports    : clock          in   sole clock, rising edge                   |
// |            reset_n        in   asynchronous active-low reset             |
// |            btn            in   raw, asynchronous, bouncy button          |
// |            level          out  debounced button state (registered)      |
// |            press_pulse    out  one-clock strobe on accepted press       |
// |            release_pulse  out  one-clock strobe on accepted release     |
// |            toggle         out  flips on every accepted press            |
// | Config   : DEBOUNCE_TOGGLE_EN - when defined the toggle latch is built;  |
// |            otherwise toggle is tied to 0.                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module button_debounce #(
  parameter int TICK_DIV       = 250000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic toggle
);

  localparam int            TICK_W    = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [3:0]    SAMPLES_C = 4'(STABLE_SAMPLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer: the only consumer of the raw button
  // --------------------------------------------------------------------------
  logic sync_meta;
  logic btn_s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      btn_s     <= 1'b0;
    end else begin
      sync_meta <= btn;
      btn_s     <= sync_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Free-running sample-tick divider
  // --------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce FSM: state register
  // --------------------------------------------------------------------------
  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic [3:0] cnt_inc;
  logic       press_ev;
  logic       release_ev;

  assign cnt_inc = cnt + 4'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce FSM: next state. Nothing moves outside tick cycles.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_ev   = 1'b0;
    release_ev = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state_nx = PRESS_CHK;
            cnt_nx   = 4'd1;
          end
        end
        PRESS_CHK: begin
          if (btn_s) begin
            if (cnt_inc == SAMPLES_C) begin
              state_nx = PRESSED;
              cnt_nx   = 4'd0;
              press_ev = 1'b1;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state_nx = REL_CHK;
            cnt_nx   = 4'd1;
          end
        end
        REL_CHK: begin
          if (!btn_s) begin
            if (cnt_inc == SAMPLES_C) begin
              state_nx   = IDLE;
              cnt_nx     = 4'd0;
              release_ev = 1'b1;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            state_nx = PRESSED;
            cnt_nx   = 4'd0;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs. level is decoded from the next state so that it
  // always matches the state register exactly; the strobes are high in the
  // clock that follows the accepting transition.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      level         <= (state_nx == PRESSED) || (state_nx == REL_CHK);
      press_pulse   <= press_ev;
      release_pulse <= release_ev;
    end
  end

`ifdef DEBOUNCE_TOGGLE_EN
  // Flips on the same edge that raises press_pulse.
  logic toggle_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_q ^ press_ev;
    end
  end

  assign toggle = toggle_q;
`else
  assign toggle = 1'b0;
`endif

endmodule
`default_nettype wire
